// File: rtl/dcache_req_resp_pkg.sv
// Shared CPU package: memory-stage FSM encoding, decode constants and the latched request record.
package dcache_req_resp_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} dc_state_e;

  localparam logic [3:0] OP_MEM   = 4'd5;
  localparam logic [3:0] OP_ATOM  = 4'd6;
  localparam logic [3:0] OP_CACHE = 4'd9;

  localparam logic [4:0] SUB_LD_B  = 5'd0;
  localparam logic [4:0] SUB_LD_H  = 5'd1;
  localparam logic [4:0] SUB_LD_W  = 5'd2;
  localparam logic [4:0] SUB_ST_B  = 5'd3;
  localparam logic [4:0] SUB_ST_H  = 5'd4;
  localparam logic [4:0] SUB_ST_W  = 5'd5;
  localparam logic [4:0] SUB_LD_BU = 5'd6;
  localparam logic [4:0] SUB_LD_HU = 5'd7;
  localparam logic [4:0] SUB_PRELD = 5'd8;
  localparam logic [4:0] SUB_LL_W  = 5'd11;
  localparam logic [4:0] SUB_SC_W  = 5'd12;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
    logic        typ;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic [3:0]  op;
    logic [4:0]  sub;
    logic [4:0]  rd;
  } mem_req_t;

  // Stores, preload, cache maintenance and misaligned halves complete silently.
  function automatic logic has_wb(input mem_req_t r);
    logic wb;
    wb = 1'b1;
    if (r.op == OP_MEM && (r.sub == SUB_ST_B || r.sub == SUB_ST_H ||
                           r.sub == SUB_ST_W || r.sub == SUB_PRELD)) wb = 1'b0;
    if (r.op == OP_CACHE) wb = 1'b0;
    if (r.size == 2'd1 && r.wstrb == 4'd0) wb = 1'b0;
    return wb;
  endfunction

endpackage

// File: rtl/dcache_req_resp_load_align.sv
// Load lane select and sign/zero extension of the returned cache word.
module load_align
  import dcache_req_resp_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [4:0]  sub,
  output logic [31:0] data
);
  logic [3:0][7:0] bytes;
  logic [7:0]      b;
  logic [15:0]     h;

  assign bytes = rdata;
  assign b     = bytes[lane];
  assign h     = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (sub)
      SUB_LD_B:  data = {{24{b[7]}}, b};
      SUB_LD_H:  data = {{16{h[15]}}, h};
      SUB_LD_BU: data = {24'd0, b};
      SUB_LD_HU: data = {16'd0, h};
      default:   data = rdata;
    endcase
  end
endmodule

// File: rtl/dcache_req_resp.sv
// MEM-stage data cache request/response sequencer with LL/SC flag and flush handling.
module dcache_req_resp
  import dcache_req_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_din,
  input  logic        pipe_type,
  input  logic [3:0]  pipe_wstrb,
  input  logic [1:0]  pipe_size,
  input  logic [31:0] pipe_ctr,
  input  logic [4:0]  pipe_rd,
  input  logic        flush,
  input  logic        llbit_clr,
  output logic        dcache_valid,
  input  logic        dcache_ready,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_din,
  output logic        dcache_type,
  output logic [3:0]  dcache_wstrb,
  output logic [1:0]  dcache_size,
  input  logic        dcache_rvalid,
  input  logic [31:0] dcache_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        llbit
);
  dc_state_e   state, state_nxt;
  mem_req_t    lat;
  logic        accept, is_sc_in, sc_fail, resp, lat_is_ll, lat_is_sc;
  logic [31:0] ld_data;
  logic        unused_ctr;

  assign unused_ctr = ^{pipe_ctr[31:12], pipe_ctr[6:4]};

  assign is_sc_in  = (pipe_ctr[3:0] == OP_ATOM) && (pipe_ctr[11:7] == SUB_SC_W);
  assign accept    = (state == S_IDLE) && pipe_valid && !flush;
  // A failed sc.w never reaches the cache; it answers 0 straight from IDLE.
  assign sc_fail   = accept && is_sc_in && !llbit;
  assign resp      = (state == S_WAIT) && dcache_rvalid && !flush;
  assign lat_is_ll = (lat.op == OP_ATOM) && (lat.sub == SUB_LL_W);
  assign lat_is_sc = (lat.op == OP_ATOM) && (lat.sub == SUB_SC_W);

  assign dcache_addr  = lat.addr;
  assign dcache_din   = lat.din;
  assign dcache_type  = lat.typ;
  assign dcache_wstrb = lat.wstrb;
  assign dcache_size  = lat.size;

  load_align u_align (
    .rdata (dcache_rdata),
    .lane  (lat.addr[1:0]),
    .sub   (lat.sub),
    .data  (ld_data)
  );

  always_comb begin
    state_nxt    = state;
    pipe_ready   = 1'b0;
    dcache_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE: begin
        pipe_ready = 1'b1;
        busy       = pipe_valid;
        if (accept && !sc_fail) state_nxt = S_REQ;
      end
      S_REQ: begin
        dcache_valid = 1'b1;
        // A flush racing the handshake still owes us a response, so drain it.
        if (flush)             state_nxt = dcache_ready ? S_DRAIN : S_IDLE;
        else if (dcache_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dcache_rvalid) state_nxt = S_IDLE;
        else if (flush)    state_nxt = S_DRAIN;
      end
      S_DRAIN: if (dcache_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      lat      <= '0;
      llbit    <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= 32'd0;
      wb_rd    <= 5'd0;
    end else begin
      state    <= state_nxt;
      wb_valid <= 1'b0;
      if (accept && !sc_fail)
        lat <= '{addr: pipe_addr, din: pipe_din, typ: pipe_type, wstrb: pipe_wstrb,
                 size: pipe_size, op: pipe_ctr[3:0], sub: pipe_ctr[11:7], rd: pipe_rd};
      if (sc_fail) begin
        wb_valid <= 1'b1;
        wb_data  <= 32'd0;
        wb_rd    <= pipe_rd;
      end else if (resp && has_wb(lat)) begin
        wb_valid <= 1'b1;
        wb_rd    <= lat.rd;
        wb_data  <= lat_is_sc ? 32'd1 : ld_data;
      end
      if (llbit_clr)               llbit <= 1'b0;
      else if (resp && lat_is_ll)  llbit <= 1'b1;
      else if (resp && lat_is_sc)  llbit <= 1'b0;
    end
  end
endmodule

// File: doc/dcache_req_resp.md
DCACHE_REQ_RESP -- requirements
Module: dcache_req_resp

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 pipe_valid  in  1  memory op presented by the MEM-stage decode.
REQ-005 pipe_ready  out  1  block accepts pipe_* this cycle.
REQ-006 pipe_addr / pipe_din  in  32 each  effective address; byte-lane-aligned store data.
REQ-007 pipe_type  in  1  0 read, 1 write.
REQ-008 pipe_wstrb  in  4  byte lanes.
REQ-009 pipe_size  in  2  0 byte, 1 half, 2 word.
REQ-010 pipe_ctr  in  32  decode word: [3:0] op type, [11:7] subtype.
REQ-011 pipe_rd  in  5  destination register.
REQ-012 flush  in  1  kill in-flight op.
REQ-013 llbit_clr  in  1  clear LLbit (ertn).
REQ-014 dcache_valid / dcache_ready  out / in  1 each  request handshake.
REQ-015 dcache_addr, dcache_din (32), dcache_type (1), dcache_wstrb (4), dcache_size (2)  out  registered request fields.
REQ-016 dcache_rvalid / dcache_rdata  in  1 / 32  response strobe and read word.
REQ-017 wb_valid (1), wb_rd (5), wb_data (32)  out  writeback result.
REQ-018 busy (1), llbit (1)  out  pipeline stall; LL/SC flag.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, DRAIN; pipe_ready=1 only in IDLE; busy = not IDLE or (pipe_valid and IDLE).
REQ-020 IDLE with pipe_valid and no flush: latch all pipe_* fields, enter REQ.
REQ-021 REQ: dcache_valid=1 with latched fields held stable; on dcache_ready go to WAIT.
REQ-022 WAIT: on dcache_rvalid, pulse wb_valid one cycle with wb_rd latched, return to IDLE.
REQ-023 Read result: subtype 0 sign-extend byte, 1 sign-extend half, 2 or ll.w (type 6, sub 11) full word, 6 zero-extend byte, 7 zero-extend half; lane chosen by latched addr[1:0].
REQ-024 Stores (type 5, sub 3-5): wb_valid=0 on response.
REQ-025 ll.w: llbit set at response.
REQ-026 sc.w (type 6, sub 12): llbit=1 issues store, then wb_data=1 and llbit cleared at response; llbit=0 goes IDLE->IDLE with no dcache request, wb_valid=1, wb_data=0 next cycle.
REQ-027 Misaligned half (wstrb=0) or type 5 sub 8 / type 9 cache ops: issued with no writeback.
REQ-028 flush in REQ before handshake: drop, return to IDLE, no dcache_valid next cycle.
REQ-029 flush in WAIT: enter DRAIN; DRAIN consumes dcache_rvalid with wb_valid=0 and then returns to IDLE.
REQ-030 flush and dcache_rvalid same cycle in WAIT: response discarded, go IDLE.
REQ-031 llbit_clr has priority over a same-cycle llbit set.
REQ-032 Latency: load result no earlier than 2 cycles after acceptance.

Reset
REQ-033 rst SHALL force IDLE, llbit=0, dcache_valid=0, wb_valid=0, wb_data=0, wb_rd=0, all latched fields 0, regardless of in-flight state.

Structure
REQ-034 FSM state encoding and op-type/subtype constants (5, 6, 9; subtypes 0-12) SHALL live in the shared CPU package.
REQ-035 Load lane select/extension SHALL be a sub-module load_align (combinational).

Verification
REQ-036 ld.b addr 0x...03, rdata 0x80FF_FF00 -> wb_data 0xFFFF_FF80.
REQ-037 ld.hu addr 0x...02, rdata 0xBEEF_1234 -> wb_data 0x0000_BEEF.
REQ-038 dcache_ready low 3 cycles -> dcache_* stable, busy=1.
REQ-039 flush in WAIT, rvalid 2 cycles later -> no wb_valid, IDLE after.
REQ-040 ll.w then sc.w -> wb_data=1; sc.w after llbit_clr -> no request, wb_data=0.
REQ-041 rst asserted in WAIT -> all outputs 0 asynchronously.
